counter_event_monitor: RTL and testbench
========================================

# counter_event_monitor

Single-clock consumer stage that sits directly downstream of a free-running micro-benchmark counter. Each cycle it samples the counter value and the counter's own reset, classifies the step as hold, increment, wrap, clear or illegal, and keeps a saturating wrap count. Wrap, clear and error steps are queued as event records in a small FIFO and drained through a valid/ready port, so counter behaviour can be checked on-fabric without a waveform.

## Interface
- CNT_W, 4: width of the observed counter value.
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2.
- WRAP_W, 8: width of the saturating wrap counter.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- count_in  in  CNT_W  observed counter value, same clock domain.
- count_clr  in  1  upstream counter's active-high synchronous reset, same cycle as the counter sees it.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready at a rising edge.
- evt_data  out  2+2*CNT_W  {type[1:0], prev[CNT_W-1:0], cur[CNT_W-1:0]}; type 01 WRAP, 10 CLEAR, 11 ERROR.
- wrap_cnt  out  WRAP_W  number of WRAP classifications since reset, saturating.
- ovf  out  1  sticky; an event was dropped because the FIFO was full.

## Operation
- Sampling registers: prev_cnt <= count_in, prev_clr <= count_clr every edge out of reset; primed <= 1 on the first such edge.
- Classification (combinational, before each edge, only when primed=1), comparing cur=count_in against prev_cnt/prev_clr:
  - prev_clr=1, cur=0, prev_cnt≠0 → CLEAR.
  - prev_clr=1, cur=0, prev_cnt=0 → no event.
  - prev_clr=1, cur≠0 → ERROR.
  - prev_clr=0, cur=prev_cnt → no event (hold).
  - prev_clr=0, prev_cnt≠max, cur=prev_cnt+1 → no event (increment).
  - prev_clr=0, prev_cnt=max (all ones), cur=0 → WRAP.
  - any other case → ERROR (skip, decrement, jump).
- primed=0: sample loaded, no classification, no event.
- WRAP increments wrap_cnt regardless of whether its event is queued; holds at 2^WRAP_W-1.
- FIFO: push of an event record accepted if not full, or if full and a pop occurs the same edge. Otherwise record dropped, ovf set; ovf clears only on reset.
- FIFO order strictly first-in-first-out; no bypass path: a record pushed into an empty FIFO is visible on the cycle after the push edge.
- evt_data held stable while evt_valid=1 and evt_ready=0.

## Timing
- Reset (rst=0 at an edge): evt_valid=0, evt_data=0, wrap_cnt=0, ovf=0, primed=0, FIFO empty, prev_cnt=0, prev_clr=0. Takes effect at that edge and overrides any simultaneous push/pop.
- Latency: upstream value changes at edge k-1. The monitor classifies during cycle k-1→k and pushes at edge k. evt_valid=1 and wrap_cnt updated after edge k when the FIFO was empty.
- Throughput: one classification and one pop per cycle; simultaneous push and pop at any occupancy is legal and keeps count unchanged.
- Empty with evt_ready=1: evt_valid stays 0; no pop.
- First post-reset edge never produces an event, even if count_in or count_clr are non-zero.

## Test plan
- Reset, then drive 0,1,…,15,0 (count_clr=0): exactly one event, evt_data={01,1111,0000}; wrap_cnt=1; ovf=0.
- Count to 7, assert count_clr one cycle so next value is 0: one event {10,0111,0000}; no WRAP; wrap_cnt unchanged.
- Drive 3 then 5: event {11,0011,0101}. Drive count_clr=1 followed by value 2: event {11,prev,0010}.
- evt_ready=0, generate 5 ERROR events: first 4 retained, 5th dropped, ovf=1. Raise evt_ready: 4 records drain in generation order, one per cycle, then evt_valid=0.
- Queue 3 events, assert rst=0 for one edge: evt_valid=0, wrap_cnt=0, ovf=0. First sample after release produces no event even with count_in=9.
- Drive 300 consecutive wraps with evt_ready=1: wrap_cnt saturates at 255. Every wrap produces one WRAP record; ovf stays 0.

Source files
------------

// File: rtl/counter_event_monitor.sv
// Watches a free-running counter, classifies each step (hold/inc/wrap/clear/illegal),
// keeps a saturating wrap count and queues wrap/clear/error records in a small FIFO.
module counter_event_monitor #(
  parameter int CNT_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_W-1:0]     count_in,
  input  logic                 count_clr,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [2+2*CNT_W-1:0] evt_data,
  output logic [WRAP_W-1:0]    wrap_cnt,
  output logic                 ovf
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = 2 + 2*CNT_W;
  localparam logic [1:0] EV_WRAP  = 2'b01;
  localparam logic [1:0] EV_CLEAR = 2'b10;
  localparam logic [1:0] EV_ERR   = 2'b11;

  logic [CNT_W-1:0] prev_cnt;
  logic             prev_clr;
  logic             primed;

  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      occ;

  logic             ev_push;
  logic [1:0]       ev_type;
  logic             full, empty, pop, push_ok;

  // Step classification against the previous sample
  always_comb begin
    ev_push = 1'b0;
    ev_type = EV_ERR;
    if (primed) begin
      if (prev_clr) begin
        if (count_in == '0) begin
          ev_push = (prev_cnt != '0);
          ev_type = EV_CLEAR;
        end else begin
          ev_push = 1'b1;
        end
      end else if (count_in == prev_cnt) begin
        ev_push = 1'b0;
      end else if (prev_cnt != '1 && count_in == prev_cnt + CNT_W'(1)) begin
        ev_push = 1'b0;
      end else if (prev_cnt == '1 && count_in == '0) begin
        ev_push = 1'b1;
        ev_type = EV_WRAP;
      end else begin
        ev_push = 1'b1;
      end
    end
  end

  assign full      = (occ == (AW+1)'(FIFO_DEPTH));
  assign empty     = (occ == '0);
  assign pop       = !empty && evt_ready;
  // A full FIFO still takes a record when the head leaves on the same edge
  assign push_ok   = ev_push && (!full || pop);
  assign evt_valid = !empty;
  assign evt_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_cnt <= '0;
      prev_clr <= 1'b0;
      primed   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      wrap_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      prev_cnt <= count_in;
      prev_clr <= count_clr;
      primed   <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
      if (ev_push && ev_type == EV_WRAP && wrap_cnt != '1)
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
      if (ev_push && !push_ok)
        ovf <= 1'b1;
    end
  end

  // Storage needs no reset; evt_data is masked while empty
  always_ff @(posedge clk) begin
    if (rst && push_ok)
      mem[wr_ptr] <= {ev_type, prev_cnt, count_in};
  end

endmodule

// File: tb/tb_counter_event_monitor.sv
// Directed bench for counter_event_monitor: hand-computed records, wrap counts and ovf.
module tb_counter_event_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_in;
  logic       count_clr;
  logic       evt_valid;
  logic       evt_ready;
  logic [9:0] evt_data;
  logic [7:0] wrap_cnt;
  logic       ovf;

  int errs = 0;
  int checks = 0;
  logic [9:0] got [$];

  counter_event_monitor #(.CNT_W(4), .FIFO_DEPTH(4), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .count_clr(count_clr),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .wrap_cnt(wrap_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Record every accepted head
  always @(posedge clk)
    if (rst && evt_valid && evt_ready) got.push_back(evt_data);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic c);
    count_in  = v;
    count_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_got(input string tag, input logic [9:0] exp []);
    chk({tag, "_n"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(tag, got[i], exp[i]);
    got.delete();
  endtask

  initial begin
    rst = 1'b0; count_in = 4'd5; count_clr = 1'b1; evt_ready = 1'b1;
    drive(4'd5, 1'b1);
    drive(4'd7, 1'b0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_data", evt_data, 0);
    chk("rst_wrap", wrap_cnt, 0);
    chk("rst_ovf", ovf, 0);

    // Full count and wrap
    rst = 1'b1;
    for (int v = 0; v < 16; v++) drive(4'(v), 1'b0);
    drive(4'd0, 1'b0);
    chk("wrap_valid", evt_valid, 1);
    chk("wrap_data", evt_data, {2'b01, 4'hf, 4'h0});
    chk("wrap_cnt1", wrap_cnt, 1);
    drive(4'd0, 1'b0);
    chk_got("wrap_rec", '{ {2'b01, 4'hf, 4'h0} });
    chk("wrap_ovf", ovf, 0);

    // Clear from 7
    for (int v = 1; v < 8; v++) drive(4'(v), 1'b0);
    drive(4'd7, 1'b1);
    drive(4'd0, 1'b0);
    drive(4'd0, 1'b0);
    chk_got("clr_rec", '{ {2'b10, 4'h7, 4'h0} });
    chk("clr_wrap", wrap_cnt, 1);

    // Skip, then non-zero after clear
    drive(4'd1, 1'b0); drive(4'd2, 1'b0); drive(4'd3, 1'b0);
    drive(4'd5, 1'b0);
    drive(4'd5, 1'b1);
    drive(4'd2, 1'b0);
    drive(4'd2, 1'b0);
    chk_got("err_rec", '{ {2'b11, 4'h3, 4'h5}, {2'b11, 4'h5, 4'h2} });

    // Overflow: five errors into a 4-deep FIFO with no consumer
    evt_ready = 1'b0;
    drive(4'd9, 1'b0); drive(4'd2, 1'b0); drive(4'd9, 1'b0); drive(4'd2, 1'b0);
    chk("full_ovf0", ovf, 0);
    drive(4'd9, 1'b0);
    chk("full_ovf1", ovf, 1);
    chk("full_head", evt_data, {2'b11, 4'h2, 4'h9});
    drive(4'd9, 1'b0);
    chk("stall_head", evt_data, {2'b11, 4'h2, 4'h9});
    evt_ready = 1'b1;
    drive(4'd9, 1'b0); drive(4'd9, 1'b0); drive(4'd9, 1'b0);
    chk("drain_valid3", evt_valid, 1);
    drive(4'd9, 1'b0);
    chk("drain_valid4", evt_valid, 0);
    chk_got("drain_rec", '{ {2'b11, 4'h2, 4'h9}, {2'b11, 4'h9, 4'h2},
                           {2'b11, 4'h2, 4'h9}, {2'b11, 4'h9, 4'h2} });

    // Reset with queued records
    evt_ready = 1'b0;
    drive(4'd1, 1'b0); drive(4'd9, 1'b0); drive(4'd1, 1'b0);
    chk("q3_valid", evt_valid, 1);
    rst = 1'b0;
    drive(4'd1, 1'b0);
    rst = 1'b1;
    chk("r2_valid", evt_valid, 0);
    chk("r2_data", evt_data, 0);
    chk("r2_wrap", wrap_cnt, 0);
    chk("r2_ovf", ovf, 0);
    drive(4'd9, 1'b0);
    chk("prime_valid", evt_valid, 0);
    drive(4'd9, 1'b0);
    chk("hold_valid", evt_valid, 0);

    // 300 wraps with the consumer always ready
    evt_ready = 1'b1;
    for (int v = 10; v < 16; v++) drive(4'(v), 1'b0);
    drive(4'd0, 1'b0);
    for (int w = 1; w < 300; w++) begin
      for (int v = 1; v < 16; v++) drive(4'(v), 1'b0);
      drive(4'd0, 1'b0);
      if (w == 254) chk("wrap_255", wrap_cnt, 255);
    end
    drive(4'd0, 1'b0);
    chk("sat_wrap", wrap_cnt, 255);
    chk("sat_ovf", ovf, 0);
    chk("sat_n", got.size(), 300);
    chk("sat_first", got.size() > 0 ? got[0] : 10'h0, {2'b01, 4'hf, 4'h0});
    chk("sat_last", got.size() > 0 ? got[got.size()-1] : 10'h0, {2'b01, 4'hf, 4'h0});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
